// File: rtl/gauss_div_ctrl.sv
// Gaussian-blur normalisation sequencer: issues sum/weight divides to `div`,
// rounds/clamps the quotient, and buffers pixels. Option: GAUSS_DIV_ROUND_EN.
module gauss_div_ctrl #(
    parameter int SUM_WIDTH    = 16,
    parameter int WEIGHT_WIDTH = 9,
    parameter int PIXEL_WIDTH  = 8,
    parameter int OUT_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SUM_WIDTH-1:0]    in_sum,
    input  logic [WEIGHT_WIDTH-1:0] in_weight,
    output logic                    div_valid_in,
    output logic [SUM_WIDTH-1:0]    div_dividend,
    output logic [WEIGHT_WIDTH-1:0] div_divisor,
    input  logic [SUM_WIDTH-1:0]    div_quotient,
    input  logic [WEIGHT_WIDTH-1:0] div_remainder,
    input  logic                    div_valid_out,
    input  logic                    div_overflow,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PIXEL_WIDTH-1:0]  out_pixel,
    output logic                    err
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);
    localparam logic [PIXEL_WIDTH-1:0] PIX_MAX = '1;
    localparam logic [SUM_WIDTH:0] PIX_MAX_W = (SUM_WIDTH + 1)'(PIX_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state, state_nxt;

    logic [PIXEL_WIDTH-1:0] mem [OUT_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic                   fifo_full, fifo_empty;

    logic                   ovf_q;
    logic                   in_hs, in_bad;
    logic                   push, pop, cap, err_set;
    logic [PIXEL_WIDTH-1:0] push_pixel, res_pixel;
    logic                   round_up;
    logic [SUM_WIDTH:0]     quot_r;

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);

    // Reset gates in_ready so nothing is offered while the block is held.
    assign in_ready = reset && (state == IDLE) && !fifo_full;
    assign in_hs    = in_valid && in_ready;
    assign in_bad   = in_sum[SUM_WIDTH-1] | in_weight[WEIGHT_WIDTH-1];

    assign div_valid_in = (state == ISSUE);

    assign out_valid = !fifo_empty;
    assign out_pixel = fifo_empty ? '0 : mem[rd_ptr];
    assign pop       = out_ready && !fifo_empty;

`ifdef GAUSS_DIV_ROUND_EN
    logic [WEIGHT_WIDTH:0] rem_x2, dvs_w;
    assign rem_x2   = {div_remainder, 1'b0};
    assign dvs_w    = {1'b0, div_divisor};
    assign round_up = (rem_x2 >= dvs_w);
`else
    logic unused_rem;
    assign unused_rem = ^div_remainder;
    assign round_up   = 1'b0;
`endif

    assign quot_r = {1'b0, div_quotient} + {{SUM_WIDTH{1'b0}}, round_up};

    // Pixel from the divider result: saturate on divide-by-zero or overrange.
    always_comb begin
        res_pixel = quot_r[PIXEL_WIDTH-1:0];
        if (ovf_q || (quot_r > PIX_MAX_W)) begin
            res_pixel = PIX_MAX;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        push_pixel = res_pixel;
        cap        = 1'b0;
        err_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_hs) begin
                    cap = 1'b1;
                    if (in_bad) begin
                        push       = 1'b1;
                        push_pixel = PIX_MAX;
                        err_set    = 1'b1;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                err_set   = div_overflow;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (div_valid_out) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, overflow latch and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_dividend <= '0;
            div_divisor  <= '0;
            ovf_q        <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (cap) begin
                div_dividend <= in_sum;
                div_divisor  <= in_weight;
            end
            if (state == ISSUE) begin
                ovf_q <= div_overflow;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_pixel;
        end
    end

    a_no_push_full: assert property (
        @(posedge clk) disable iff (!reset) !(push && fifo_full));
    a_no_pop_empty: assert property (
        @(posedge clk) disable iff (!reset) !(pop && fifo_empty));

endmodule

// File: tb/tb_gauss_div_ctrl.sv
// Bench for gauss_div_ctrl: behavioural divider plus a queue-based
// reference model, directed cases and a randomized run.
module tb_gauss_div_ctrl;

    localparam int SW = 16;
    localparam int WW = 9;
    localparam int PW = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] in_sum = '0;
    logic [WW-1:0] in_weight = '0;
    logic          div_valid_in;
    logic [SW-1:0] div_dividend;
    logic [WW-1:0] div_divisor;
    logic [SW-1:0] div_quotient = '0;
    logic [WW-1:0] div_remainder = '0;
    logic          div_valid_out = 1'b0;
    logic          div_overflow;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] out_pixel;
    logic          err;

    gauss_div_ctrl #(
        .SUM_WIDTH(SW), .WEIGHT_WIDTH(WW), .PIXEL_WIDTH(PW), .OUT_DEPTH(D)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_weight(in_weight),
        .div_valid_in(div_valid_in), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_quotient(div_quotient),
        .div_remainder(div_remainder), .div_valid_out(div_valid_out),
        .div_overflow(div_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .err(err)
    );

    always #5 clk = ~clk;

    assign div_overflow = div_valid_in && (div_divisor == '0);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_pix(input logic [SW-1:0] s,
                                   input logic [WW-1:0] w);
        int si, wi, q, r;
        si = int'(s);
        wi = int'(w);
        if (si >= (1 << (SW - 1)) || wi >= (1 << (WW - 1)) || wi == 0)
            return (1 << PW) - 1;
        q = si / wi;
        r = si % wi;
`ifdef GAUSS_DIV_ROUND_EN
        if (2 * r >= wi) q = q + 1;
`endif
        if (q > (1 << PW) - 1) q = (1 << PW) - 1;
        return q;
    endfunction

    // Behavioural iterative divider with random latency.
    bit            dm_busy = 0;
    int            dm_lat = 0;
    logic [SW-1:0] dm_a;
    logic [WW-1:0] dm_b;
    int            div_starts = 0;
    bit            spur_en = 0;

    always @(negedge clk) begin
        if (!reset) begin
            dm_busy = 0;
            div_valid_out = 1'b0;
        end else begin
            div_valid_out = 1'b0;
            if (dm_busy) begin
                if (dm_lat == 0) begin
                    div_valid_out = 1'b1;
                    dm_busy = 0;
                    if (dm_b == '0) begin
                        div_quotient = '1;
                        div_remainder = '0;
                    end else begin
                        div_quotient = SW'(dm_a / SW'(dm_b));
                        div_remainder = WW'(dm_a % SW'(dm_b));
                    end
                end else begin
                    dm_lat--;
                end
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                div_valid_out = 1'b1;
                div_quotient = SW'($urandom);
                div_remainder = WW'($urandom);
            end
            if (div_valid_in) begin
                chk("one_in_flight", 32'(dm_busy), 0);
                dm_busy = 1;
                dm_a = div_dividend;
                dm_b = div_divisor;
                dm_lat = $urandom_range(0, 5);
                div_starts++;
            end
        end
    end

    // Reference model and per-cycle compare.
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] got_q[$];
    bit            err_m = 0;
    bit            pend = 0;
    logic [SW-1:0] pend_s;
    logic [WW-1:0] pend_w;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            pend = 0;
            err_m = 0;
        end else begin
            if (pend) begin
                chk("issue_latency", 32'(div_valid_in), 1);
                chk("div_dividend", 32'(div_dividend), 32'(pend_s));
                chk("div_divisor", 32'(div_divisor), 32'(pend_w));
                pend = 0;
            end else if (div_valid_in) begin
                chk("issue_unexpected", 32'(div_valid_in), 0);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(PW'(exp_pix(in_sum, in_weight)));
                if (in_sum[SW-1] || in_weight[WW-1]) begin
                    err_m = 1;
                end else begin
                    if (in_weight == '0) err_m = 1;
                    pend = 1;
                    pend_s = in_sum;
                    pend_w = in_weight;
                end
            end
            if (out_valid) begin
                chk("pixel_extra", 32'(exp_q.size() > 0), 1);
                if (out_ready && exp_q.size() > 0) begin
                    chk("pixel", 32'(out_pixel), 32'(exp_q[0]));
                    got_q.push_back(out_pixel);
                    void'(exp_q.pop_front());
                end
            end
            if (!err_m) chk("err_no_cause", 32'(err), 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_rdy(input bit v);
        @(posedge clk);
        #1;
        out_ready = v;
    endtask

    task automatic send(input int s, input int w);
        int t = 0;
        @(posedge clk);
        #1;
        in_sum = SW'(s);
        in_weight = WW'(w);
        in_valid = 1'b1;
        while (!in_ready && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t < 300) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("send_timeout", 32'(t < 300), 1);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid || dm_busy) && t < 2000) begin
            tick();
            t++;
        end
        chk("drain_timeout", 32'(t < 2000), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        repeat (2) tick();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    bit rnd_done;

    initial begin
        int s0, t;

        // Reset state
        repeat (2) tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_div_valid_in", 32'(div_valid_in), 0);
        chk("rst_dividend", 32'(div_dividend), 0);
        chk("rst_divisor", 32'(div_divisor), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_pixel", 32'(out_pixel), 0);
        chk("rst_err", 32'(err), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        chk("idle_in_ready", 32'(in_ready), 1);

        // 15900 / 159 = 100 with latency checks
        got_q.delete();
        send(15900, 159);
        tick();
        chk("issue_1cycle", 32'(div_valid_in), 1);
        t = 0;
        while (!div_valid_out && t < 50) begin
            tick();
            t++;
        end
        chk("div_result_seen", 32'(div_valid_out), 1);
        chk("out_valid_before", 32'(out_valid), 0);
        tick();
        chk("out_valid_1cycle", 32'(out_valid), 1);
        chk("pix_15900", 32'(out_pixel), 100);
        drain();
        chk("err_after_100", 32'(err), 0);

        // 239 / 159 : q=1 r=80
        got_q.delete();
        send(239, 159);
        drain();
        chk("cnt_239", 32'(got_q.size()), 1);
`ifdef GAUSS_DIV_ROUND_EN
        chk("pix_239", 32'(got_q[0]), 2);
`else
        chk("pix_239", 32'(got_q[0]), 1);
`endif

        // Clamp without error
        got_q.delete();
        send(32767, 9);
        drain();
        chk("pix_clamp", 32'(got_q[0]), 255);
        chk("err_clamp", 32'(err), 0);

        // Backpressure: six pairs, FIFO holds four
        set_rdy(1'b0);
        s0 = div_starts;
        got_q.delete();
        fork
            begin
                for (int i = 1; i <= 6; i++) send(159 * i, 159);
            end
        join_none
        repeat (60) tick();
        chk("bp_divs", 32'(div_starts - s0), 4);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        set_rdy(1'b1);
        wait fork;
        drain();
        chk("bp_count", 32'(got_q.size()), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++)
            chk("bp_order", 32'(got_q[i]), 32'(i + 1));

        // Divide by zero
        got_q.delete();
        send(1000, 0);
        drain();
        chk("pix_div0", 32'(got_q[0]), 255);
        chk("err_div0", 32'(err), 1);
        repeat (5) tick();
        chk("err_sticky", 32'(err), 1);

        // Out-of-range sum: no divide issued
        s0 = div_starts;
        got_q.delete();
        send(32768, 159);
        drain();
        chk("bad_no_div", 32'(div_starts - s0), 0);
        chk("pix_bad", 32'(got_q[0]), 255);
        chk("err_bad", 32'(err), 1);

        // Reset during WAIT
        do_reset();
        chk("err_cleared", 32'(err), 0);
        got_q.delete();
        send(30000, 3);
        tick();
        chk("rw_issue", 32'(div_valid_in), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("rw_out_valid", 32'(out_valid), 0);
        chk("rw_in_ready", 32'(in_ready), 0);
        repeat (2) tick();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        chk("rw_in_ready_after", 32'(in_ready), 1);
        repeat (10) tick();
        chk("rw_no_push", 32'(got_q.size()), 0);
        send(1590, 159);
        drain();
        chk("rw_count", 32'(got_q.size()), 1);
        chk("rw_pix", 32'(got_q[0]), 10);

        // Randomized traffic with backpressure and stray div strobes
        spur_en = 1;
        rnd_done = 0;
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    int s, w, k;
                    w = $urandom_range(1, 255);
                    k = $urandom_range(0, 9);
                    if (k < 6)
                        s = (w * $urandom_range(0, 300) +
                             $urandom_range(0, w - 1)) & 32'h7fff;
                    else
                        s = $urandom_range(0, 32767);
                    if (k == 7) w = 0;
                    if (k == 8) w = w | 256;
                    if (k == 9) s = s | 32768;
                    send(s, w);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        set_rdy(1'b1);
        drain();
        chk("rnd_drained", 32'(exp_q.size()), 0);
        chk("rnd_err", 32'(err), 32'(err_m));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gauss_div_ctrl.md
Name: gauss_div_ctrl

Overview:
- Normalisation sequencer between the Gaussian-blur weighted-sum stage and the shared iterative `div` unit.
- Takes (weighted sum, kernel weight) pairs on a valid/ready stream and issues one division at a time to `div`.
- Captures each quotient/remainder, rounds, clamps to pixel range, and buffers the pixel in a small output FIFO that feeds the gradient stage.
- The divider has no backpressure, so this block guarantees every `div` result has a free FIFO slot.

Parameters:
SUM_WIDTH, 16, weighted-sum width; equals `div` DIVIDEND_WIDTH
WEIGHT_WIDTH, 9, kernel-weight width; equals `div` DIVISOR_WIDTH (9 so 159 is positive)
PIXEL_WIDTH, 8, output pixel width
OUT_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
in_valid  in  1  sum/weight pair valid
in_ready  out  1  pair accepted when in_valid & in_ready
in_sum  in  SUM_WIDTH  weighted sum (unsigned, MSB must be 0)
in_weight  in  WEIGHT_WIDTH  kernel weight (unsigned, MSB must be 0, nonzero)
div_valid_in  out  1  one-cycle start pulse to `div`
div_dividend  out  SUM_WIDTH  registered in_sum
div_divisor  out  WEIGHT_WIDTH  registered in_weight
div_quotient  in  SUM_WIDTH  `div` quotient
div_remainder  in  WEIGHT_WIDTH  `div` remainder
div_valid_out  in  1  `div` result strobe
div_overflow  in  1  `div` divide-by-zero flag (combinational in its INIT cycle)
out_valid  out  1  FIFO not empty
out_ready  in  1  downstream pop
out_pixel  out  PIXEL_WIDTH  FIFO head
err  out  1  sticky: any out-of-range input or div_overflow since reset

Behaviour:
- Reset (reset=0, async):
  - Outputs: state=IDLE, in_ready=0, div_valid_in=0, div_dividend/div_divisor=0, out_valid=0, out_pixel=0, err=0.
  - FIFO emptied; any in-flight division is abandoned.
  - Top level resets `div` on the same event.
- FSM IDLE:
  - in_ready = (count < OUT_DEPTH), where count = FIFO occupancy.
  - On handshake, register the pair.
  - If in_sum MSB=1 or in_weight MSB=1: push saturated 2^PIXEL_WIDTH-1, set err, stay IDLE, no divide issued.
  - Otherwise go to ISSUE.
- FSM ISSUE:
  - Assert div_valid_in for exactly this cycle; div_dividend/div_divisor hold the registered pair.
  - Latch div_overflow into ovf_q; if set, also set err.
  - Go to WAIT. in_ready=0.
- FSM WAIT:
  - in_ready=0. Stay until div_valid_out=1.
  - On the div_valid_out cycle, compute the pixel and push it; go to IDLE.
  - A new pair is accepted at the earliest on the cycle after the push.
- Pixel computation:
  - If ovf_q=1: pixel = 2^PIXEL_WIDTH-1.
  - Otherwise r = div_quotient (+1 when rounding, see Optional Feature), computed in SUM_WIDTH+1 bits.
  - pixel = min(r, 2^PIXEL_WIDTH-1).
- At most one division is in flight. Because IDLE only accepts with count<OUT_DEPTH, a slot is always reserved for the result.
- div_valid_out while not in WAIT: ignored, no push.
- FIFO:
  - First-word fall-through, in-order; out_pixel = head entry.
  - Push and pop in the same cycle: count unchanged.
  - Pop on empty and push on full cannot occur; assertions check both.
  - Pointers wrap modulo OUT_DEPTH.
- Latency: div_valid_out cycle to out_valid is 1 cycle (FIFO previously empty). Handshake to div_valid_in is 1 cycle.
- Reset mid-WAIT: return to IDLE, no push, FIFO empty.

Optional Feature:
GAUSS_DIV_ROUND_EN
- Defined: round to nearest. Add 1 to the quotient when 2*div_remainder >= div_divisor (compare in WEIGHT_WIDTH+1 bits).
- Undefined: truncate; the quotient is used as-is and the remainder is ignored.

Test Plan:
- Sum 15900, weight 159, out_ready=1 -> out_pixel=100, err=0; out_valid exactly 1 cycle after div_valid_out.
- Sum 239, weight 159 (q=1, r=80) -> out_pixel=2 with GAUSS_DIV_ROUND_EN defined, 1 without.
- Sum 32767, weight 9 (q=3640) -> out_pixel=255 (clamp), err=0. Weight 0 -> out_pixel=255, err=1, stays 1.
- out_ready=0, offer 6 pairs (sums 159, 318, 477, 636, 795, 954; weight 159) -> 4 divisions complete, in_ready=0 with FIFO full.
  - Raise out_ready: pixels 1,2,3,4,5,6 in order, none lost or duplicated.
- Sum 0x8000 -> no div_valid_in pulse, out_pixel=255, err=1.
- Assert reset during WAIT (divisor 3, sum 30000) -> out_valid=0 and in_ready=0 during reset, in_ready=1 after release.
  - The next pair (1590/159) yields exactly one pixel, 10.
